div32_seq: RTL and testbench

Sequential 32-bit unsigned restoring divider that produces one quotient bit per clock. It instantiates one `adder32` in subtract mode (`cin`=1) as its only arithmetic element. Each cycle it drives the shifted partial remainder and the divisor into that adder, then consumes the difference and the `cout` sign flag. It serves as the multicycle divide unit beside the ALU adder.

---
 rtl/div32_seq.sv | 117 +++++++++++
 tb/tb_div32_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div32_seq.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per clock.
// A single adder32 in subtract mode is the only arithmetic element.

module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] res;

  // cin=1 selects subtract: sum = a - b, cout is the borrow out.
  always_comb begin
    if (cin) res = {1'b0, a} - {1'b0, b};
    else     res = {1'b0, a} + {1'b0, b};
  end

  assign sum  = res[31:0];
  assign cout = res[32];
endmodule

module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_r, r_r, d_r;
  logic [4:0]       count;

  logic [WIDTH-1:0] p, t, r_next, q_next;
  logic             s, borrow, accept;

  // The bit shifted out of R means the partial remainder is >= 2^32,
  // so the subtraction must succeed regardless of the adder's borrow.
  assign p      = {r_r[WIDTH-2:0], q_r[WIDTH-1]};
  assign s      = r_r[WIDTH-1];
  assign accept = s | ~borrow;
  assign r_next = accept ? t : p;
  assign q_next = {q_r[WIDTH-2:0], accept};

  adder32 u_sub (
    .a    (p),
    .b    (d_r),
    .cin  (1'b1),
    .sum  (t),
    .cout (borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor != '0) begin
              q_r         <= dividend;
              d_r         <= divisor;
              r_r         <= '0;
              count       <= '0;
              div_by_zero <= 1'b0;
              state       <= RUN;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RUN: begin
          q_r   <= q_next;
          r_r   <= r_next;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            quotient  <= q_next;
            remainder <= r_next;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // A divide-by-zero enters here with done low and pulses it next cycle.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed vector table, hand-written
// multi-cycle sequences and randomized operands against an arithmetic model.

module tb_div32_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div32_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done; returns latency in cycles
  // after the accepting edge, 0 on timeout. Inputs are scrambled after acceptance.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_ok);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat      = 0;
    busy_ok  = busy;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_idle_after(input string name);
    @(posedge clk); #1;
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_done"}, done, 0);
  endtask

  initial begin
    int          lat, dones, done_at;
    logic        bok;
    logic [31:0] a, b, eq, er;
    logic        edz;

    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 32};
    tbl[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 32};
    tbl[2] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 32};
    tbl[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1,          1'b0, 32};
    tbl[4] = '{32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,          1'b0, 32};
    tbl[5] = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1, 1};
    tbl[6] = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 32};
    tbl[7] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 32};
    tbl[8] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1, 1};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      do_div(tbl[k].a, tbl[k].b, lat, bok);
      chk($sformatf("vec%0d_lat", k), lat, tbl[k].lat);
      chk($sformatf("vec%0d_busy", k), bok, 1);
      chk($sformatf("vec%0d_quot", k), quotient, tbl[k].q);
      chk($sformatf("vec%0d_rem", k), remainder, tbl[k].r);
      chk($sformatf("vec%0d_dz", k), div_by_zero, tbl[k].dz);
      check_idle_after($sformatf("vec%0d", k));
    end

    // 50/5 with a second request pulsed at E10 that must be ignored.
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; done_at = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 10) begin
        start = 1'b1; dividend = 32'd8; divisor = 32'd2;
      end
      @(posedge clk); #1;
      if (i == 10) start = 1'b0;
      if (done) begin
        dones++;
        if (done_at == 0) begin
          done_at = i;
          chk("ign_quot", quotient, 10);
          chk("ign_rem", remainder, 0);
        end
      end
    end
    chk("ign_done_at", done_at, 32);
    chk("ign_done_count", dones, 1);
    chk("ign_end_busy", busy, 0);

    // 1000/3 aborted by reset at E15, then rerun.
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quot", quotient, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("abort_no_activity", dones, 0);
    do_div(32'd1000, 32'd3, lat, bok);
    chk("rerun_lat", lat, 32);
    chk("rerun_quot", quotient, 333);
    chk("rerun_rem", remainder, 1);
    check_idle_after("rerun");

    // Randomized operands with extreme values mixed in.
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'd0;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 16);
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 0) begin
        eq = 32'hFFFF_FFFF; er = a; edz = 1'b1;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0;
      end
      do_div(a, b, lat, bok);
      chk($sformatf("rnd%0d_lat", n), lat, (b == 0) ? 1 : 32);
      chk($sformatf("rnd%0d_quot", n), quotient, eq);
      chk($sformatf("rnd%0d_rem", n), remainder, er);
      chk($sformatf("rnd%0d_dz", n), div_by_zero, edz);
      if (b != 0) begin
        chk($sformatf("rnd%0d_inv", n),
            64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
        chk($sformatf("rnd%0d_rem_lt", n), remainder < b, 1);
      end
      check_idle_after($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
